// File: rtl/upbus_arb_if.sv
// upbus_arb_if: internal CPU bus (155 MHz domain) shared by the arbiter and the
// addressed sub-blocks.
//   upa      - bus address
//   updi     - bus write data
//   uprs     - one-cycle read strobe
//   upws     - one-cycle write strobe
//   upactive - a transaction is in progress
//   updo     - read data from the addressed block, valid with uprdy
//   uprdy    - ready/completion from the addressed block
// modport master: the arbiter side.  modport slave: the sub-block side.
interface upbus_arb_if #(
  parameter int AW = 24,
  parameter int DW = 32
) ();
  logic [AW-1:0] upa;
  logic [DW-1:0] updi;
  logic          uprs;
  logic          upws;
  logic          upactive;
  logic [DW-1:0] updo;
  logic          uprdy;

  modport master (
    output upa, updi, uprs, upws, upactive,
    input  updo, uprdy
  );

  modport slave (
    input  upa, updi, uprs, upws, upactive,
    output updo, uprdy
  );
endinterface

// File: rtl/upbus_arb.sv
// upbus_arb: two-master round-robin arbiter and transaction sequencer for the
// internal CPU bus. Master 0 is the external-CPU path, master 1 the internal
// config/loader engine. Each granted access issues one read or write strobe,
// waits for uprdy (bounded by TOUT cycles) and returns data/ack to the owner.
// Ports:
//   clk155, rst_            - bus clock, synchronous active-low reset
//   mN_req/rnw/a/di         - master N request, direction, address, write data
//   mN_do/ack/err           - master N read data, completion pulse, timeout flag
//   bus (master modport)    - upa/updi/uprs/upws/upactive out, updo/uprdy in
//   gnt                     - owner of the current/last transaction
//   tout_evt                - one-cycle pulse when a transfer ends by timeout
//   err_cnt, err_clr        - saturating timeout counter and its clear
module upbus_arb #(
  parameter int            AW    = 24,
  parameter int            DW    = 32,
  parameter int            TW    = 8,
  parameter int            TOUT  = 200,
  parameter logic [DW-1:0] TOVAL = 32'hDEAD_DEAD
) (
  input  logic           clk155,
  input  logic           rst_,
  input  logic           m0_req,
  input  logic           m0_rnw,
  input  logic [AW-1:0]  m0_a,
  input  logic [DW-1:0]  m0_di,
  output logic [DW-1:0]  m0_do,
  output logic           m0_ack,
  output logic           m0_err,
  input  logic           m1_req,
  input  logic           m1_rnw,
  input  logic [AW-1:0]  m1_a,
  input  logic [DW-1:0]  m1_di,
  output logic [DW-1:0]  m1_do,
  output logic           m1_ack,
  output logic           m1_err,
  upbus_arb_if.master    bus,
  output logic           gnt,
  output logic           tout_evt,
  output logic [15:0]    err_cnt,
  input  logic           err_clr
);

  typedef enum logic [2:0] {
    S_IDLE, S_STROBE, S_WAIT, S_DONE, S_RECOV
  } state_t;

  // cnt counts monitored cycles from the strobe cycle (cnt=0) onward, so the
  // last monitored cycle is the one where cnt equals TOUT-1.
  localparam logic [TW-1:0] CNT_LAST = TW'(TOUT - 1);

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          rnw_q, rnw_d;
  logic [AW-1:0] upa_q, upa_d;
  logic [DW-1:0] updi_q, updi_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          tout_q, tout_d;
  logic [15:0]   errc_q, errc_d;
  logic          sel;
  logic          done;

  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rnw_d   = rnw_q;
    upa_d   = upa_q;
    updi_d  = updi_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tout_d  = tout_q;
    errc_d  = errc_q;
    sel     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // Under contention the master that did not win last time goes next.
          sel     = (m0_req && m1_req) ? ~last_q : m1_req;
          gnt_d   = sel;
          last_d  = sel;
          rnw_d   = sel ? m1_rnw : m0_rnw;
          upa_d   = sel ? m1_a   : m0_a;
          updi_d  = sel ? m1_di  : m0_di;
          cnt_d   = '0;
          tout_d  = 1'b0;
          state_d = S_STROBE;
        end
      end
      S_STROBE, S_WAIT: begin
        if (bus.uprdy) begin
          data_d  = rnw_q ? bus.updo : '0;
          tout_d  = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = rnw_q ? TOVAL : '0;
          tout_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_RECOV;
      S_RECOV: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Clear wins over a simultaneous timeout increment.
    if (err_clr) begin
      errc_d = '0;
    end else if (done && tout_q && (errc_q != 16'hFFFF)) begin
      errc_d = errc_q + 16'd1;
    end
  end

  always_ff @(posedge clk155) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rnw_q   <= 1'b0;
      upa_q   <= '0;
      updi_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      tout_q  <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rnw_q   <= rnw_d;
      upa_q   <= upa_d;
      updi_q  <= updi_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tout_q  <= tout_d;
      errc_q  <= errc_d;
    end
  end

  assign bus.upa      = upa_q;
  assign bus.updi     = updi_q;
  assign bus.uprs     = (state_q == S_STROBE) &&  rnw_q;
  assign bus.upws     = (state_q == S_STROBE) && !rnw_q;
  assign bus.upactive = (state_q == S_STROBE) || (state_q == S_WAIT) || done;

  assign m0_ack   = done && !gnt_q;
  assign m1_ack   = done &&  gnt_q;
  assign m0_err   = m0_ack && tout_q;
  assign m1_err   = m1_ack && tout_q;
  assign m0_do    = m0_ack ? data_q : '0;
  assign m1_do    = m1_ack ? data_q : '0;
  assign tout_evt = done && tout_q;
  assign gnt      = gnt_q;
  assign err_cnt  = errc_q;

endmodule
